// File: rtl/relobi_addr_map_ctrl_pkg.sv
// Shared helpers for the triplicated address-map controller: width derivation
// and the saturating fault counter increment.
package relobi_addr_map_ctrl_pkg;

    localparam int unsigned FaultCntW = 16;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [FaultCntW-1:0] sat_inc(input logic [FaultCntW-1:0] v);
        return (&v) ? v : v + FaultCntW'(1);
    endfunction

endpackage

// File: rtl/relobi_tmr_entry_voter.sv
// Bitwise 2-of-3 majority voter with a flag raised when any copy disagrees
// with the voted result.
module relobi_tmr_entry_voter #(
    parameter int unsigned Width = 1
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic [Width-1:0] c,
    output logic [Width-1:0] voted,
    output logic             mismatch
);

    assign voted    = (a & b) | (a & c) | (b & c);
    assign mismatch = |((a ^ voted) | (b ^ voted) | (c ^ voted));

endmodule

// File: rtl/relobi_addr_map_ctrl.sv
// Holds three copies of the crossbar address map and default routes, accepts
// single-entry writes and periodically votes/rewrites one entry at a time.
module relobi_addr_map_ctrl
    import relobi_addr_map_ctrl_pkg::*;
#(
    parameter int unsigned             NumAddrRules  = 0,
    parameter int unsigned             NumSbrPorts   = 0,
    parameter int unsigned             NumMgrPorts   = 0,
    parameter type                     addr_map_rule_t = logic,
    parameter int unsigned             ScrubInterval = 16,
    parameter logic [NumSbrPorts-1:0]  RstEnDefault  = '0,
    parameter logic [31:0]             RstDefaultIdx = '0
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_ni,
    input  logic                                                   scrub_en_i,
    input  logic                                                   cfg_req_i,
    output logic                                                   cfg_gnt_o,
    input  logic [min1_clog2(NumAddrRules+NumSbrPorts)-1:0]        cfg_idx_i,
    input  logic [$bits(addr_map_rule_t)-1:0]                      cfg_rule_i,
    input  logic                                                   cfg_en_default_i,
    input  logic [min1_clog2(NumMgrPorts)-1:0]                     cfg_default_idx_i,
    output logic                                                   cfg_err_o,
    output addr_map_rule_t [2:0][NumAddrRules-1:0]                 addr_map_o,
    output logic [2:0][NumSbrPorts-1:0]                            en_default_idx_o,
    output logic [2:0][NumSbrPorts-1:0][min1_clog2(NumMgrPorts)-1:0] default_idx_o,
    output logic                                                   fault_o,
    output logic [FaultCntW-1:0]                                   fault_cnt_o
);

    localparam int unsigned NumEntries = NumAddrRules + NumSbrPorts;
    localparam int unsigned EntryW     = min1_clog2(NumEntries);
    localparam int unsigned IdxW       = min1_clog2(NumMgrPorts);
    localparam int unsigned RuleW      = $bits(addr_map_rule_t);
    localparam int unsigned DefW       = IdxW + 1;
    localparam int unsigned EntW       = (RuleW > DefW) ? RuleW : DefW;
    localparam int unsigned CntW       = min1_clog2(ScrubInterval);
    localparam logic [CntW-1:0] CntReload =
        (ScrubInterval == 0) ? '0 : CntW'(ScrubInterval - 1);

    typedef enum logic {
        IDLE,
        SCRUB
    } scrub_state_e;

    scrub_state_e    state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [EntryW-1:0] scrub_ptr_q, scrub_ptr_d;
    logic              scrub_active;

    addr_map_rule_t [2:0][NumAddrRules-1:0]      addr_map_q;
    logic [2:0][NumSbrPorts-1:0]                 en_default_q;
    logic [2:0][NumSbrPorts-1:0][IdxW-1:0]       default_idx_q;

    logic [2:0][EntW-1:0] scrub_sel;
    logic [EntW-1:0]      scrub_voted;
    logic                 scrub_mismatch;

    logic                 idx_in_range;
    logic                 wr_en;
    logic                 fault_q;
    logic                 err_q;
    logic [FaultCntW-1:0] fault_cnt_q;

    assign cfg_gnt_o    = cfg_req_i & (state_q != SCRUB);
    assign idx_in_range = 32'(cfg_idx_i) < NumEntries;
    assign wr_en        = cfg_gnt_o & idx_in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= CntReload;
            scrub_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scrub_ptr_q <= scrub_ptr_d;
        end
    end

    // The interval counter only runs while scrubbing is allowed; a scrub step
    // always lasts one cycle and then reloads the interval.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        scrub_ptr_d  = scrub_ptr_q;
        scrub_active = 1'b0;
        case (state_q)
            IDLE: begin
                if (scrub_en_i) begin
                    if (cnt_q == '0) begin
                        if (ScrubInterval != 0) begin
                            state_d = SCRUB;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            SCRUB: begin
                scrub_active = 1'b1;
                cnt_d        = CntReload;
                state_d      = IDLE;
                scrub_ptr_d  = (scrub_ptr_q == EntryW'(NumEntries - 1)) ?
                               '0 : scrub_ptr_q + EntryW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Bring every copy of the selected entry onto a common width for voting.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            scrub_sel[c] = '0;
            for (int unsigned r = 0; r < NumAddrRules; r++) begin
                if (scrub_ptr_q == EntryW'(r)) begin
                    scrub_sel[c][RuleW-1:0] = addr_map_q[c][r];
                end
            end
            for (int unsigned k = 0; k < NumSbrPorts; k++) begin
                if (scrub_ptr_q == EntryW'(NumAddrRules + k)) begin
                    scrub_sel[c][DefW-1:0] = {en_default_q[c][k], default_idx_q[c][k]};
                end
            end
        end
    end

    relobi_tmr_entry_voter #(
        .Width (EntW)
    ) i_voter (
        .a        (scrub_sel[0]),
        .b        (scrub_sel[1]),
        .c        (scrub_sel[2]),
        .voted    (scrub_voted),
        .mismatch (scrub_mismatch)
    );

    // Scrub and write never coincide because the grant is withheld in SCRUB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_map_q <= '0;
            for (int c = 0; c < 3; c++) begin
                en_default_q[c] <= RstEnDefault;
                for (int unsigned k = 0; k < NumSbrPorts; k++) begin
                    default_idx_q[c][k] <= RstDefaultIdx[IdxW-1:0];
                end
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                for (int unsigned r = 0; r < NumAddrRules; r++) begin
                    if (scrub_active && scrub_ptr_q == EntryW'(r)) begin
                        addr_map_q[c][r] <= addr_map_rule_t'(scrub_voted[RuleW-1:0]);
                    end else if (wr_en && cfg_idx_i == EntryW'(r)) begin
                        addr_map_q[c][r] <= addr_map_rule_t'(cfg_rule_i);
                    end
                end
                for (int unsigned k = 0; k < NumSbrPorts; k++) begin
                    if (scrub_active && scrub_ptr_q == EntryW'(NumAddrRules + k)) begin
                        en_default_q[c][k]  <= scrub_voted[IdxW];
                        default_idx_q[c][k] <= scrub_voted[IdxW-1:0];
                    end else if (wr_en && cfg_idx_i == EntryW'(NumAddrRules + k)) begin
                        en_default_q[c][k]  <= cfg_en_default_i;
                        default_idx_q[c][k] <= cfg_default_idx_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q     <= 1'b0;
            err_q       <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            fault_q <= scrub_active & scrub_mismatch;
            err_q   <= cfg_gnt_o & ~idx_in_range;
            if (scrub_active && scrub_mismatch) begin
                fault_cnt_q <= sat_inc(fault_cnt_q);
            end
        end
    end

    assign addr_map_o       = addr_map_q;
    assign en_default_idx_o = en_default_q;
    assign default_idx_o    = default_idx_q;
    assign fault_o          = fault_q;
    assign cfg_err_o        = err_q;
    assign fault_cnt_o      = fault_cnt_q;

endmodule

// File: doc/relobi_addr_map_ctrl.md
# relobi_addr_map_ctrl

Configuration and scrubbing controller for the triplicated address map of the reliable OBI crossbar. It holds three independent copies of every address rule and of every per-subordinate-port default-route setting, and drives them straight onto the crossbar's `addr_map_i`, `en_default_idx_i` and `default_idx_i` inputs. It accepts single-entry writes over a req/gnt port and periodically majority-votes and rewrites each entry, so that upsets in the map registers are repaired before they accumulate.

## Interface
- `NumAddrRules`, 0: number of address rules; must be ≥1.
- `NumSbrPorts`, 0: number of crossbar subordinate ports; must be ≥1.
- `NumMgrPorts`, 0: number of crossbar manager ports; IdxW = max(1, $clog2(NumMgrPorts)).
- `addr_map_rule_t`, logic: packed rule struct, identical to the crossbar's.
- `ScrubInterval`, 16: idle cycles between scrub steps; 0 disables scrubbing.
- `RstEnDefault`, '0: reset value of `en_default_idx` per subordinate port, [NumSbrPorts-1:0].
- `RstDefaultIdx`, '0: reset value of `default_idx` for every subordinate port.
- Derived: NumEntries = NumAddrRules + NumSbrPorts; EntryW = max(1, $clog2(NumEntries)).
- Ports:
  - `clk_i`, in, 1: clock, single clock domain.
  - `rst_ni`, in, 1: asynchronous active-low reset.
  - `scrub_en_i`, in, 1: allows scrub steps.
  - `cfg_req_i`, in, 1: write request.
  - `cfg_gnt_o`, out, 1: write accepted this cycle.
  - `cfg_idx_i`, in, EntryW: entry index; indices 0..NumAddrRules-1 are rules, and NumAddrRules+k is the default setting of subordinate port k.
  - `cfg_rule_i`, in, $bits(addr_map_rule_t): rule data.
  - `cfg_en_default_i`, in, 1: default enable, used for default entries.
  - `cfg_default_idx_i`, in, IdxW: default index, used for default entries.
  - `cfg_err_o`, out, 1: pulses one cycle after a granted write with cfg_idx_i ≥ NumEntries.
  - `addr_map_o`, out, [2:0][NumAddrRules-1:0] rules: three map copies.
  - `en_default_idx_o`, out, [2:0][NumSbrPorts-1:0]: three copies of the default enables.
  - `default_idx_o`, out, [2:0][NumSbrPorts-1:0][IdxW-1:0]: three copies of the default indices.
  - `fault_o`, out, 1: pulses one cycle when a scrub step finds a mismatch.
  - `fault_cnt_o`, out, 16: count of corrected entries, saturating at 16'hFFFF.

## Operation
- States:
  - IDLE: interval counter counts down.
  - SCRUB: exactly one cycle; processes entry `scrub_ptr`.
- IDLE → SCRUB when the counter is 0, `scrub_en_i`=1 and ScrubInterval≠0.
  - In SCRUB, the counter reloads to ScrubInterval-1 and the FSM returns to IDLE.
  - When `scrub_en_i`=0, the counter holds its value.
- SCRUB step:
  - Bitwise 2-of-3 vote over the three copies of entry `scrub_ptr`; the voted value is written to all three copies.
  - Any copy differing from the vote raises `fault_o` next cycle and increments `fault_cnt_o`.
  - `scrub_ptr` advances, wrapping NumEntries-1 → 0.
- `cfg_gnt_o` = `cfg_req_i` & (state≠SCRUB). This is combinational, so a write and a scrub never occur in the same cycle.
- A granted write updates all three copies of the addressed entry.
  - An out-of-range index updates nothing and raises `cfg_err_o`.
  - `scrub_ptr` and the counter are unaffected by writes.
- A write while the request is held during SCRUB is granted in the following cycle.

## Timing
- Reset values:
  - all rule copies '0;
  - en_default copies = RstEnDefault; default_idx copies = RstDefaultIdx;
  - `cfg_gnt_o`=0, `fault_o`=0, `cfg_err_o`=0, `fault_cnt_o`=0;
  - state IDLE, counter = ScrubInterval-1, scrub_ptr=0.
- Write latency: new values appear on all three output copies on the cycle after the req&gnt edge.
- Scrub latency: the corrected value and `fault_o` appear on the cycle after the SCRUB cycle.
- Scrub period: one entry every ScrubInterval+1 cycles; a full map pass takes NumEntries·(ScrubInterval+1) cycles.
- Reset asserted mid-write or mid-scrub: everything returns to reset values asynchronously, and no partial update survives.
- A fault on two copies of the same bit is voted to the wrong value and rewritten; this is a known limitation and raises `fault_o`.

## Structure
- No new package types. NumEntries, EntryW and IdxW are module-local localparams.
- Storage is three flat register arrays per field group; outputs are direct register reads, with no output voting.
- One sub-module, `relobi_tmr_entry_voter`.
  - It is parameterised by width.
  - It takes three vectors and returns the voted vector plus a mismatch flag.
  - It is instantiated once, on the `scrub_ptr`-selected entry, with the entry muxed to a common width.

## Test plan
- **Reset defaults:** release reset with RstEnDefault=2'b10 → rules '0, en_default_idx_o[j]=2'b10 for j=0..2, fault_cnt_o=0.
- **Rule write:** write entry 1 with rule {start 32'h1000, end 32'h2000, idx 1}.
  - cfg_gnt_o=1 in the same cycle.
  - All three copies of addr_map_o[*][1] equal the rule on the next cycle.
- **Single-copy fault:** force-flip bit 3 of copy 2 of rule 0 with ScrubInterval=4.
  - Within NumEntries·5 cycles the bit is restored.
  - fault_o pulses exactly once and fault_cnt_o=1.
- **Write against scrub:** hold cfg_req_i through a SCRUB cycle → cfg_gnt_o=0 in SCRUB and 1 in the following cycle; the data is written once.
- **Out-of-range write:** write with cfg_idx_i=NumEntries → no entry changes; cfg_err_o pulses one cycle.
- **Reset mid-operation:** assert rst_ni during SCRUB with scrub_ptr=3 → all outputs return to reset values; after release the first scrub targets entry 0.
